// File: rtl/mask_pkg.sv
// Shared definitions for the mask arithmetic unit: widths, the reserved
// all-ones address, op codes, FSM states, completion status codes and the
// bitwise combine function used when building the write data.
package mask_pkg;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] ONES_ADDR = 8'hff;

    localparam logic [2:0] MOP_COPY  = 3'd0;
    localparam logic [2:0] MOP_NOT   = 3'd1;
    localparam logic [2:0] MOP_AND   = 3'd2;
    localparam logic [2:0] MOP_OR    = 3'd3;
    localparam logic [2:0] MOP_XOR   = 3'd4;
    localparam logic [2:0] MOP_ANDN  = 3'd5;
    localparam logic [2:0] MOP_CLEAR = 3'd6;
    localparam logic [2:0] MOP_SET   = 3'd7;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_ABORT  = 2'b01;
    localparam logic [1:0] ST_BADDST = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_A   = 3'd1,
        WAIT_A = 3'd2,
        RD_B   = 3'd3,
        WAIT_B = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6
    } state_e;

    // Ops 0..5 need source A.
    function automatic logic op_reads_a(input logic [2:0] op);
        return (op != MOP_CLEAR) && (op != MOP_SET);
    endfunction

    // Ops 2..5 also need source B.
    function automatic logic op_reads_b(input logic [2:0] op);
        return (op >= MOP_AND) && (op <= MOP_ANDN);
    endfunction

    function automatic logic [DATA_W-1:0] mask_combine(input logic [2:0] op,
                                                       input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
        case (op)
            MOP_COPY:  return a;
            MOP_NOT:   return ~a;
            MOP_AND:   return a & b;
            MOP_OR:    return a | b;
            MOP_XOR:   return a ^ b;
            MOP_ANDN:  return a & ~b;
            MOP_CLEAR: return '0;
            default:   return '1;
        endcase
    endfunction

endpackage

// File: rtl/mask_popcount.sv
// Combinational population count of a 128-bit mask, built as an adder tree
// (per-byte counts, then pairwise sums). The parent registers the result.
//   mask  in  128  mask to count
//   count out 8    number of ones (0..128)
module mask_popcount
    import mask_pkg::*;
(
    input  logic [DATA_W-1:0] mask,
    output logic [7:0]        count
);

    logic [3:0] l0 [16];
    logic [4:0] l1 [8];
    logic [5:0] l2 [4];
    logic [6:0] l3 [2];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            l0[i] = 4'd0;
            for (int j = 0; j < 8; j++) begin
                l0[i] = l0[i] + {3'd0, mask[8*i+j]};
            end
        end
        for (int i = 0; i < 8; i++) l1[i] = {1'b0, l0[2*i]} + {1'b0, l0[2*i+1]};
        for (int i = 0; i < 4; i++) l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
        for (int i = 0; i < 2; i++) l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
        count = {1'b0, l3[0]} + {1'b0, l3[1]};
    end

endmodule

// File: rtl/mask_arith_unit.sv
// Mask arithmetic unit: reads up to two masks from the mask memory, combines
// them bitwise, writes the result back and reports its population count.
// Only touches the memory while alive=0.
//   clk, reset            clock, synchronous active-high reset
//   alive                 CPU owns the mask memory; aborts a running command
//   cmd_valid/cmd_ready   command handshake; cmd_op/src_a/src_b/dst fields
//   busy, done            command in progress / one-cycle completion pulse
//   status                00 ok, 01 aborted, 10 illegal destination
//   result_popcount       ones in the written mask (valid with done)
//   mau_*                 mask memory port; data_read has 1-cycle latency
module mask_arith_unit
    import mask_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alive,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [7:0]        result_popcount,
    output logic              mau_clk_en,
    output logic [ADDR_W-1:0] mau_address,
    output logic [DATA_W-1:0] mau_data_write,
    output logic              mau_wren,
    input  logic [DATA_W-1:0] data_read
);

    state_e            state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              clk_en_q;
    logic              wren_q;
    logic [7:0]        pc;

    assign cmd_ready = (state == IDLE) && !alive && !reset;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // alive can rise in the very cycle we are presenting a write; the port
    // must go quiet immediately, not one cycle later.
    assign mau_clk_en = clk_en_q && !alive;
    assign mau_wren   = wren_q && !alive;

    // Counts the registered write data, so the count is ready as WRITE ends.
    mask_popcount u_popcount (
        .mask  (mau_data_write),
        .count (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            op_q            <= '0;
            src_b_q         <= '0;
            dst_q           <= '0;
            op_a            <= '0;
            op_b            <= '0;
            clk_en_q        <= 1'b0;
            wren_q          <= 1'b0;
            status          <= ST_OK;
            result_popcount <= '0;
            mau_address     <= '0;
            mau_data_write  <= '0;
        end else if (alive && (state != IDLE) && (state != DONE)) begin
            state           <= DONE;
            clk_en_q        <= 1'b0;
            wren_q          <= 1'b0;
            status          <= ST_ABORT;
            result_popcount <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    op_q    <= cmd_op;
                    src_b_q <= cmd_src_b;
                    dst_q   <= cmd_dst;
                    if (cmd_dst == ONES_ADDR) begin
                        state           <= DONE;
                        status          <= ST_BADDST;
                        result_popcount <= '0;
                    end else if (op_reads_a(cmd_op)) begin
                        state       <= RD_A;
                        mau_address <= cmd_src_a;
                        clk_en_q    <= 1'b1;
                        wren_q      <= 1'b0;
                    end else begin
                        state          <= WRITE;
                        mau_address    <= cmd_dst;
                        mau_data_write <= mask_combine(cmd_op, '0, '0);
                        clk_en_q       <= 1'b1;
                        wren_q         <= 1'b1;
                    end
                end
                RD_A: state <= WAIT_A;
                // Address is still src_a here, so the ONES_ADDR substitution
                // applies to the data being captured.
                WAIT_A: begin
                    op_a <= data_read;
                    if (op_reads_b(op_q)) begin
                        state       <= RD_B;
                        mau_address <= src_b_q;
                    end else begin
                        state          <= WRITE;
                        mau_address    <= dst_q;
                        mau_data_write <= mask_combine(op_q, data_read, op_b);
                        wren_q         <= 1'b1;
                    end
                end
                RD_B: state <= WAIT_B;
                WAIT_B: begin
                    op_b           <= data_read;
                    state          <= WRITE;
                    mau_address    <= dst_q;
                    mau_data_write <= mask_combine(op_q, op_a, data_read);
                    wren_q         <= 1'b1;
                end
                WRITE: begin
                    state           <= DONE;
                    clk_en_q        <= 1'b0;
                    wren_q          <= 1'b0;
                    status          <= ST_OK;
                    result_popcount <= pc;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mask_arith_unit.sv
// Directed bench for mask_arith_unit with a behavioural mask memory
// (1-cycle read latency, address 0xff reads as all ones).
module tb_mask_arith_unit;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         alive = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [7:0]   cmd_src_a = '0;
    logic [7:0]   cmd_src_b = '0;
    logic [7:0]   cmd_dst = '0;
    logic         busy;
    logic         done;
    logic [1:0]   status;
    logic [7:0]   result_popcount;
    logic         mau_clk_en;
    logic [7:0]   mau_address;
    logic [127:0] mau_data_write;
    logic         mau_wren;
    logic [127:0] data_read;

    mask_arith_unit dut (
        .clk             (clk),
        .reset           (reset),
        .alive           (alive),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_src_a       (cmd_src_a),
        .cmd_src_b       (cmd_src_b),
        .cmd_dst         (cmd_dst),
        .busy            (busy),
        .done            (done),
        .status          (status),
        .result_popcount (result_popcount),
        .mau_clk_en      (mau_clk_en),
        .mau_address     (mau_address),
        .mau_data_write  (mau_data_write),
        .mau_wren        (mau_wren),
        .data_read       (data_read)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mask memory model; preload and clear go through the same process.
    logic [127:0] mem [256];
    logic [127:0] ram_q = '0;
    logic         pre_clr = 1'b0;
    logic         pre_we = 1'b0;
    logic [7:0]   pre_addr = '0;
    logic [127:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mau_clk_en) begin
            if (mau_wren) mem[mau_address] <= mau_data_write;
            ram_q <= mem[mau_address];
        end
    end

    assign data_read = (mau_address == 8'hff) ? '1 : ram_q;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [127:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},  cmd_ready, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_done"},   done, 0);
        check({tag, "_clken"},  mau_clk_en, 0);
        check({tag, "_wren"},   mau_wren, 0);
        check({tag, "_status"}, status, 0);
        check({tag, "_pc"},     result_popcount, 0);
        check({tag, "_addr"},   mau_address, 0);
        check({tag, "_wdata"},  mau_data_write, 0);
    endtask

    // Issues one command, then watches up to 20 cycles for the write and the
    // done pulse. Offsets are relative to the accept cycle; -1 = not seen.
    // alive_at >= 0 raises alive in that cycle offset.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] d, input int alive_at,
                           output int wr_off, output logic [7:0] wr_addr,
                           output logic [127:0] wr_data, output int done_off);
        int t0;
        cmd_op = op; cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_valid = 1'b1;
        #1;
        check("accept_ready", cmd_ready, 1);
        t0 = cyc;
        tick();
        cmd_valid = 1'b0;
        wr_off = -1; wr_addr = '0; wr_data = '0; done_off = -1;
        for (int k = 0; k < 20; k++) begin
            if (alive_at >= 0 && (cyc - t0) == alive_at) begin
                alive = 1'b1;
                #1;
            end
            if (mau_wren) begin
                wr_off = cyc - t0; wr_addr = mau_address; wr_data = mau_data_write;
            end
            if (done) begin
                done_off = cyc - t0;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wo, dn;
        logic [7:0] wa;
        logic [127:0] wd;

        tick();
        pre_clr = 1'b1; tick(); pre_clr = 1'b0;
        preload(8'd3, {8{16'h00FF}});
        preload(8'd5, {16{8'h0F}});
        preload(8'd2, {16{8'hAA}});
        preload(8'd4, {16{8'h5A}});
        check_reset("rst");
        reset = 1'b0;
        #1;
        check("idle_ready", cmd_ready, 1);

        // AND 3,5 -> 9
        run_cmd(3'd2, 8'd3, 8'd5, 8'd9, -1, wo, wa, wd, dn);
        check("and_wr_off", wo, 5);
        check("and_wr_addr", wa, 9);
        check("and_wr_data", wd, {8{16'h000F}});
        check("and_done_off", dn, 6);
        check("and_status", status, 0);
        check("and_pc", result_popcount, 32);
        check("and_busy_in_done", busy, 1);
        tick();
        check("and_busy_after", busy, 0);
        check("and_done_after", done, 0);
        check("and_mem9", mem[9], {8{16'h000F}});

        // NOT of the all-ones address -> 4
        run_cmd(3'd1, 8'hff, 8'd0, 8'd4, -1, wo, wa, wd, dn);
        check("not_wr_off", wo, 3);
        check("not_wr_data", wd, 0);
        check("not_done_off", dn, 4);
        check("not_pc", result_popcount, 0);
        tick();
        check("not_mem4", mem[4], 0);

        // SET -> 7
        run_cmd(3'd7, 8'd0, 8'd0, 8'd7, -1, wo, wa, wd, dn);
        check("set_wr_off", wo, 1);
        check("set_wr_addr", wa, 7);
        check("set_wr_data", wd, '1);
        check("set_done_off", dn, 2);
        check("set_pc", result_popcount, 128);
        tick();
        check("set_pc_hold", result_popcount, 128);
        check("set_status_hold", status, 0);

        // CLEAR to the read-only address: rejected, no write
        run_cmd(3'd6, 8'd0, 8'd0, 8'hff, -1, wo, wa, wd, dn);
        check("bad_wr_off", wo, -1);
        check("bad_done_off", dn, 1);
        check("bad_status", status, 2);
        check("bad_pc", result_popcount, 0);
        tick();

        // OR aborted by alive in WAIT_A
        run_cmd(3'd3, 8'd3, 8'd5, 8'd10, 2, wo, wa, wd, dn);
        check("abort_wr_off", wo, -1);
        check("abort_done_off", dn, 3);
        check("abort_status", status, 1);
        check("abort_pc", result_popcount, 0);
        tick();
        check("abort_ready_alive", cmd_ready, 0);
        check("abort_mem10", mem[10], 0);

        // Command held while alive=1 is not accepted
        cmd_op = 3'd0; cmd_src_a = 8'd9; cmd_dst = 8'd11; cmd_valid = 1'b1;
        tick();
        check("alive_ready", cmd_ready, 0);
        check("alive_clken", mau_clk_en, 0);
        check("alive_busy", busy, 0);
        alive = 1'b0;
        run_cmd(3'd0, 8'd9, 8'd0, 8'd11, -1, wo, wa, wd, dn);
        check("copy_wr_off", wo, 3);
        check("copy_wr_data", wd, {8{16'h000F}});
        check("copy_done_off", dn, 4);
        check("copy_pc", result_popcount, 32);
        tick();

        // Reset during RD_B abandons the XOR into 2
        cmd_op = 3'd4; cmd_src_a = 8'd3; cmd_src_b = 8'd5; cmd_dst = 8'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("rdb_clken", mau_clk_en, 1);
        check("rdb_addr", mau_address, 5);
        reset = 1'b1;
        #1;
        check("rdb_ready_in_reset", cmd_ready, 0);
        tick();
        check_reset("midrst");
        reset = 1'b0;
        tick();
        check("midrst_mem2", mem[2], {16{8'hAA}});

        // XOR with src_a = src_b = dst
        run_cmd(3'd4, 8'd2, 8'd2, 8'd2, -1, wo, wa, wd, dn);
        check("xor_wr_off", wo, 5);
        check("xor_wr_data", wd, 0);
        check("xor_done_off", dn, 6);
        check("xor_pc", result_popcount, 0);
        check("xor_status", status, 0);
        tick();
        check("xor_mem2", mem[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mask_arith_unit.md
Name: mask_arith_unit

Overview:
Mask arithmetic unit (MAU). It drives the MAU-side port of the GPU mask memory (256 x 128-bit masks). Each command reads up to two source masks, combines them bitwise and writes the result to a destination mask. It also reports the population count of the result. It runs only while the GPU is not alive (alive=0), which is when the mask memory routes its MAU port to the RAM.

Parameters:
DATA_W, 128, mask width in bits
ADDR_W, 8, mask memory address width
ONES_ADDR, 8'hff, read-only address that always returns all ones

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
alive  in  1  1 = CPU owns mask memory; MAU must not access it
cmd_valid  in  1  command request
cmd_ready  out  1  unit can accept a command this cycle
cmd_op  in  3  operation code
cmd_src_a  in  8  source A address
cmd_src_b  in  8  source B address
cmd_dst  in  8  destination address
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
status  out  2  00 ok, 01 aborted (alive rose), 10 illegal destination; valid with done
result_popcount  out  8  number of ones in the written mask (0..128); valid with done
mau_clk_en  out  1  mask memory clock enable
mau_address  out  8  mask memory address
mau_data_write  out  128  write data
mau_wren  out  1  write enable
data_read  in  128  mask memory read data; 1-cycle RAM latency; ONES_ADDR gives all ones

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - cmd_ready, busy, done, mau_clk_en, mau_wren = 0.
  - status=00, result_popcount=0, mau_address=0, mau_data_write=0.
  - Registers opA, opB = 0.
  - Reset mid-command abandons the command with no write.
- cmd_ready = (state==IDLE) & !alive & !reset. A command is accepted when cmd_valid & cmd_ready; all cmd_* fields are latched on acceptance.
- Op codes:
  - 0 COPY: A
  - 1 NOT: ~A
  - 2 AND: A&B
  - 3 OR: A|B
  - 4 XOR: A^B
  - 5 ANDN: A&~B
  - 6 CLEAR: 0
  - 7 SET: all ones
- Source usage:
  - Ops 0-1 read A only.
  - Ops 2-5 read A and B.
  - Ops 6-7 read nothing.
- States: IDLE -> RD_A -> WAIT_A -> RD_B -> WAIT_B -> WRITE -> DONE -> IDLE.
  - RD_B/WAIT_B are skipped for unary ops.
  - RD_A, WAIT_A, RD_B, WAIT_B are all skipped for ops 6-7.
- RD_x: mau_address=src, mau_clk_en=1, mau_wren=0.
- WAIT_x: the same address is held with mau_clk_en=1. data_read is captured into opA/opB at the end of this cycle. Holding the address is mandatory because the all-ones substitution at ONES_ADDR decodes the current address.
- WRITE: mau_address=dst, mau_data_write=result, mau_wren=1, mau_clk_en=1 for exactly one cycle.
  - The popcount of result is registered in this cycle.
- DONE: done=1 for one cycle, status and result_popcount valid; busy=0 from the next cycle.
- busy=1 in every state except IDLE.
- mau_clk_en and mau_wren are 0 in IDLE and DONE.
- Latency for a binary op accepted in cycle T: write in T+5, done in T+6. Unary op: write T+3, done T+4. CLEAR/SET: write T+1, done T+2.
- Illegal destination (cmd_dst==ONES_ADDR):
  - No RAM access.
  - IDLE -> DONE on the next cycle, with status=10 and result_popcount=0.
- alive rises while busy (any state before DONE):
  - Go to DONE next cycle with status=01.
  - mau_wren is forced 0 in that cycle; no write occurs.
  - result_popcount=0.
- Sources equal to ONES_ADDR are legal and read as all ones. src_a==src_b is legal.
- A destination equal to a source is legal: reads complete before the write.
- result_popcount and status hold their values until the next done.

Decomposition:
- Package mask_pkg:
  - op codes (MOP_COPY..MOP_SET)
  - state enum
  - status codes (ST_OK, ST_ABORT, ST_BADDST)
  - ONES_ADDR, DATA_W, ADDR_W
- Sub-module mask_popcount: combinational 128-bit -> 8-bit population count (adder tree). The parent registers its output.

Test Plan:
- Preload mask[3]=0x00FF..00FF, mask[5]=0x0F0F..0F0F; op AND src_a=3 src_b=5 dst=9 accepted at T -> write at T+5 of 0x000F..000F to addr 9; done at T+6; status 00; popcount 32.
- Op NOT src_a=0xff dst=4 -> mask[4]=0; popcount 0; done at T+4.
- Op SET dst=7 -> write at T+1 of all ones; done T+2; popcount 128. Op CLEAR dst=0xff -> no mau_wren ever; done T+1; status 10.
- Op OR accepted, alive driven high in WAIT_A -> no write cycle; done next cycle; status 01; cmd_ready stays 0 until alive=0.
- reset asserted during RD_B -> next cycle all outputs at reset values; destination unchanged; then a new XOR src=dst=2 with mask[2]=0xAAAA.. -> mask[2]=0; popcount 0.
- alive=1 with cmd_valid=1 -> cmd_ready=0, mau_clk_en=0; command accepted the cycle after alive falls.
